tt_dfd_ffs_req_collector: RTL

Upstream collection and holding stage for the team's generic find-first-set selector (the combinational priority encoder with data mux). Gives each of NUM_SRC trace/debug sources a one-entry pending slot with a valid/ready handshake, and drives the pending vector and slot data to the selector. It consumes the selector's one-hot pick, loads it into a registered output stage, and clears the granted slot. A per-slot age counter forces service of starved low-priority sources.

---
 rtl/tt_dfd_ffs_req_collector.sv | 130 +++++++++++++
 1 files changed

// File: rtl/tt_dfd_ffs_req_collector.sv
// tt_dfd_ffs_req_collector
// Per-source one-entry holding slots feeding an external find-first-set
// selector. The selector's pick is registered into an output stage with a
// valid/ready handshake. A per-slot age counter masks the request vector so
// that starved low-priority slots are forced through.
module tt_dfd_ffs_req_collector #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int SRC_IDW      = ($clog2(NUM_SRC) > 1 ? $clog2(NUM_SRC) : 1),
    parameter int STARVE_LIMIT = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_SRC-1:0]              src_valid,
    output logic [NUM_SRC-1:0]              src_ready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data,
    output logic [NUM_SRC-1:0]              ffs_req,
    output logic [NUM_SRC*DATA_WIDTH-1:0]   ffs_data,
    input  logic                            ffs_any,
    input  logic [NUM_SRC-1:0]              ffs_sel,
    input  logic [DATA_WIDTH-1:0]           ffs_sel_data,
    input  logic [SRC_IDW-1:0]              ffs_sel_enc,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [SRC_IDW-1:0]              out_src,
    output logic                            starve_active
);

    localparam int AGE_W = (STARVE_LIMIT > 0) ? (($clog2(STARVE_LIMIT + 1) > 0) ? $clog2(STARVE_LIMIT + 1) : 1) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);
    localparam bit STARVE_EN = (STARVE_LIMIT != 0);

    // Saturating age increment; the counter parks at the starvation threshold.
    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
        return (a >= AGE_MAX) ? a : a + AGE_W'(1);
    endfunction

    logic [NUM_SRC-1:0]     pend_p0;
    logic [DATA_WIDTH-1:0]  slot_data_p0 [NUM_SRC];
    logic [AGE_W-1:0]       age_p0 [NUM_SRC];
    logic [NUM_SRC-1:0]     starving;
    logic [NUM_SRC-1:0]     accept;
    logic [NUM_SRC-1:0]     grant;
    logic                   load;

    logic                   vld_p1;
    logic [DATA_WIDTH-1:0]  out_data_p1;
    logic [SRC_IDW-1:0]     out_src_p1;

    // Handshake and grant decode; a slot being granted is still pending, so it cannot refill this cycle.
    always_comb begin
        src_ready = ~pend_p0 & {NUM_SRC{~reset}};
        accept    = src_valid & src_ready;
        load      = ffs_any & (~vld_p1 | out_ready);
        grant     = load ? ffs_sel : '0;
    end

    // Starvation detect and request masking toward the selector.
    always_comb begin
        starving = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            starving[i] = STARVE_EN & pend_p0[i] & (age_p0[i] == AGE_MAX);
        end
        starve_active = |starving;
        if (reset) begin
            ffs_req = '0;
        end else if (|starving) begin
            ffs_req = pend_p0 & starving;
        end else begin
            ffs_req = pend_p0;
        end
    end

    // Slot payloads go to the selector unmasked.
    always_comb begin
        ffs_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ffs_data[i*DATA_WIDTH +: DATA_WIDTH] = slot_data_p0[i];
        end
    end

    // ---- stage p0: slot occupancy and ageing ----
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_p0 <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                age_p0[i] <= '0;
            end
        end else begin
            pend_p0 <= (pend_p0 & ~grant) | accept;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!pend_p0[i] || grant[i]) begin
                    age_p0[i] <= '0;
                end else begin
                    age_p0[i] <= age_sat_inc(age_p0[i]);
                end
            end
        end
    end

    // Slot payload capture on accept; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (accept[i]) begin
                slot_data_p0[i] <= src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ---- stage p1: registered output with hold under backpressure ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            out_data_p1 <= '0;
            out_src_p1  <= '0;
        end else if (load) begin
            vld_p1      <= 1'b1;
            out_data_p1 <= ffs_sel_data;
            out_src_p1  <= ffs_sel_enc;
        end else if (out_ready) begin
            vld_p1      <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = out_data_p1;
    assign out_src   = out_src_p1;

endmodule
